// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores against a big-endian 32-bit-port
// memory; sub-word stores are read-modify-write, illegal accesses answer with resp_err.
module load_store_unit #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state, state_nxt;
   logic        rdy_q, accept, bad, retire;
   logic        q_we, q_uns, q_err;
   logic [1:0]  q_size;
   logic [15:0] q_wdata;
   logic [32:0] addr_end;
   logic [31:0] ld_ext, st_merge;
   logic        rdy_nxt, mem_read_nxt, mem_write_nxt, resp_valid_nxt, resp_err_nxt;
   logic [31:0] resp_rdata_nxt, mem_addr_nxt, mem_wdata_nxt;

   assign req_ready = rdy_q & ~rst;
   assign accept    = req_valid & req_ready;
   assign retire    = resp_valid & resp_ready;
   assign addr_end  = {1'b0, req_addr} + 33'd4;
   assign bad = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
              | (addr_end > 33'(MEM_BYTES));

   // Addressed byte always lands in the top lane of the returned word.
   always_comb begin
      ld_ext   = mem_rdata;
      st_merge = {q_wdata, mem_rdata[15:0]};
      case (q_size)
         2'b00: begin
            ld_ext   = q_uns ? {24'd0, mem_rdata[31:24]} : {{24{mem_rdata[31]}}, mem_rdata[31:24]};
            st_merge = {q_wdata[7:0], mem_rdata[23:0]};
         end
         2'b01: ld_ext = q_uns ? {16'd0, mem_rdata[31:16]} : {{16{mem_rdata[31]}}, mem_rdata[31:16]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            if (bad)                            state_nxt = RESP;
            else if (req_we && req_size == 2'b10) state_nxt = WR;
            else                                state_nxt = RD;
         end
         RD:      state_nxt = q_we ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    if (retire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes trail the state by one edge; read data is taken on the edge that ends mem_read.
   always_comb begin
      mem_read_nxt   = (state == RD);
      mem_write_nxt  = (state == WR);
      resp_valid_nxt = (state == RESP) & ~retire;
      resp_err_nxt   = resp_valid_nxt & q_err;
      rdy_nxt        = (state_nxt == IDLE);
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      resp_rdata_nxt = resp_rdata;
      if (accept && !bad) begin
         mem_addr_nxt = req_addr;
         if (req_we) mem_wdata_nxt = req_wdata;
      end
      if (accept)                resp_rdata_nxt = 32'd0;
      else if (mem_read && !q_we) resp_rdata_nxt = ld_ext;
      if (mem_read && q_we)      mem_wdata_nxt  = st_merge;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_we    <= 1'b0;
         q_uns   <= 1'b0;
         q_err   <= 1'b0;
         q_size  <= 2'b00;
         q_wdata <= 16'd0;
      end else if (accept) begin
         q_we    <= req_we;
         q_uns   <= req_unsigned;
         q_err   <= bad;
         q_size  <= req_size;
         q_wdata <= req_wdata[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q      <= 1'b1;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
      end else begin
         rdy_q      <= rdy_nxt;
         mem_read   <= mem_read_nxt;
         mem_write  <= mem_write_nxt;
         resp_valid <= resp_valid_nxt;
         resp_err   <= resp_err_nxt;
         resp_rdata <= resp_rdata_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array big-endian memory model.
module tb_load_store_unit;
   localparam int MEM_BYTES = 1024;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        resp_valid, resp_ready, resp_err, mem_read, mem_write;
   logic        mem_init;

   logic [7:0]  mem [MEM_BYTES];
   int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rd0, wr0, lat;
   logic [31:0] last_wdata = 0, last_waddr = 0;
   int          tests = 0, fails = 0;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always_comb begin
      int ia;
      ia = int'(mem_addr[9:0]);
      mem_rdata = 32'd0;
      if (mem_addr <= 32'd1020) mem_rdata = {mem[ia], mem[ia+1], mem[ia+2], mem[ia+3]};
   end

   always @(posedge clk) begin
      int ia;
      ia = int'(mem_addr[9:0]);
      if (mem_init) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
         mem[12] <= 8'h1A; mem[13] <= 8'h2A; mem[14] <= 8'hAA; mem[15] <= 8'h0F; mem[16] <= 8'h0B;
      end else if (mem_write && mem_addr <= 32'd1020) begin
         mem[ia] <= mem_wdata[31:24]; mem[ia+1] <= mem_wdata[23:16];
         mem[ia+2] <= mem_wdata[15:8]; mem[ia+3] <= mem_wdata[7:0];
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write) begin
         wr_cnt     <= wr_cnt + 1;
         last_wdata <= mem_wdata;
         last_waddr <= mem_addr;
      end
      if (mem_read && mem_write) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request and return #1 after its accept edge, with inputs scrambled.
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
      rd0 = rd_cnt; wr0 = wr_cnt;
   endtask

   task automatic wait_resp(output int l);
      l = 0;
      while (!resp_valid && l < 10) begin @(posedge clk); #1; l++; end
   endtask

   task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err, input int n_rd, input int n_wr);
      int l;
      send(we, sz, uns, a, wd);
      wait_resp(l);
      chk({tag, ".lat"},   32'(l), 32'(exp_lat));
      chk({tag, ".rdata"}, resp_rdata, exp_rd);
      chk({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
      chk({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(n_rd));
      chk({tag, ".writes"},32'(wr_cnt - wr0), 32'(n_wr));
      @(posedge clk); #1;
      chk({tag, ".retired"}, {30'd0, resp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0; mem_init = 1'b0;
      @(posedge clk); #1;
      chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst.flags", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
      chk("rst.resp_rdata", resp_rdata, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.mem_wdata", mem_wdata, 32'd0);

      xact("ld_w12",  0, 2'b10, 0, 32'd12, 0, 2, 32'h1A2AAA0F, 0, 1, 0);
      xact("ld_b14s", 0, 2'b00, 0, 32'd14, 0, 2, 32'hFFFFFFAA, 0, 1, 0);
      xact("ld_b14u", 0, 2'b00, 1, 32'd14, 0, 2, 32'h000000AA, 0, 1, 0);
      xact("ld_h14s", 0, 2'b01, 0, 32'd14, 0, 2, 32'hFFFFAA0F, 0, 1, 0);
      xact("ld_h12u", 0, 2'b01, 1, 32'd12, 0, 2, 32'h00001A2A, 0, 1, 0);

      xact("st_b13",  1, 2'b00, 0, 32'd13, 32'hFFFFFF77, 3, 32'd0, 0, 1, 1);
      chk("st_b13.wdata", last_wdata, 32'h77AA0F0B);
      chk("st_b13.waddr", last_waddr, 32'd13);
      xact("ld_w12b", 0, 2'b10, 0, 32'd12, 0, 2, 32'h1A77AA0F, 0, 1, 0);
      xact("ld_b16",  0, 2'b00, 0, 32'd16, 0, 2, 32'h0000000B, 0, 1, 0);

      xact("st_w24",  1, 2'b10, 0, 32'd24, 32'hCAFEF00D, 2, 32'd0, 0, 0, 1);
      xact("ld_w24",  0, 2'b10, 0, 32'd24, 0, 2, 32'hCAFEF00D, 0, 1, 0);
      xact("st_h28",  1, 2'b01, 0, 32'd28, 32'hABCD1234, 3, 32'd0, 0, 1, 1);
      chk("st_h28.wdata", last_wdata, 32'h12341E1F);
      xact("ld_h28s", 0, 2'b01, 0, 32'd28, 0, 2, 32'h00001234, 0, 1, 0);

      xact("err_w6",    0, 2'b10, 0, 32'd6,    0, 1, 32'd0, 1, 0, 0);
      xact("err_h9st",  1, 2'b01, 0, 32'd9,    32'h1111, 1, 32'd0, 1, 0, 0);
      xact("err_h1022", 0, 2'b01, 0, 32'd1022, 0, 1, 32'd0, 1, 0, 0);
      xact("err_sz3",   0, 2'b11, 0, 32'd0,    0, 1, 32'd0, 1, 0, 0);
      xact("err_b1021", 0, 2'b00, 0, 32'd1021, 0, 1, 32'd0, 1, 0, 0);
      xact("ok_w1020",  0, 2'b10, 0, 32'd1020, 0, 2, 32'hFCFDFEFF, 0, 1, 0);

      // Back-pressure, then retire and accept back to back.
      resp_ready = 1'b0;
      send(0, 2'b10, 0, 32'd12, 0);
      wait_resp(lat);
      chk("hold.lat", 32'(lat), 32'd2);
      rd0 = rd_cnt; wr0 = wr_cnt;
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold.valid", {31'd0, resp_valid}, 32'd1);
         chk("hold.rdata", resp_rdata, 32'h1A77AA0F);
         chk("hold.ready", {31'd0, req_ready}, 32'd0);
      end
      chk("hold.strobes", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
      @(negedge clk);
      resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b1; req_addr = 32'd14;
      @(posedge clk); #1;
      chk("b2b.retire", {30'd0, resp_valid, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk("b2b.accept", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      wait_resp(lat);
      chk("b2b.lat", 32'(lat), 32'd2);
      chk("b2b.rdata", resp_rdata, 32'h000000AA);
      @(posedge clk); #1;

      // Reset while the read-modify-write is about to write.
      send(1, 2'b00, 0, 32'd20, 32'h55);
      @(posedge clk); #1;
      chk("rstwr.read", {31'd0, mem_read}, 32'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rstwr.strobes", {30'd0, mem_read, mem_write}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rstwr.ready", {30'd0, resp_valid, req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("rstwr.noresp", {31'd0, resp_valid}, 32'd0);
      chk("rstwr.nowrite", 32'(wr_cnt - wr0), 32'd0);
      xact("ld_b20", 0, 2'b00, 1, 32'd20, 0, 2, 32'h00000014, 0, 1, 0);

      chk("never_both", 32'(both_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
